// File: rtl/button_conditioner_pkg.sv
// Shared constants for the button conditioning front end of timer_counter.
// Button bit positions on the raw input bus and the production debounce length.
package button_conditioner_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;
    localparam int N_BTN_DEFAULT           = 4;

    localparam int BTN_INV   = 0;
    localparam int BTN_MODE  = 1;
    localparam int BTN_START = 2;
    localparam int BTN_STOP  = 3;

endpackage

// File: rtl/button_conditioner_if.sv
// Bundle of raw button inputs and conditioned level/pulse outputs.
// The master drives raw inputs and the pulse enable; the slave is the conditioner.
interface button_conditioner_if #(
    parameter int N_BTN = 4
);
    logic             ena;
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_rise;
    logic [N_BTN-1:0] btn_fall;

    modport master (
        output ena,
        output btn_raw,
        input  btn_level,
        input  btn_rise,
        input  btn_fall
    );

    modport slave (
        input  ena,
        input  btn_raw,
        output btn_level,
        output btn_rise,
        output btn_fall
    );
endinterface

// File: rtl/button_conditioner_debounce_channel.sv
// One button bit: two-flop synchronizer, consecutive-stable-count filter,
// and registered one-cycle rise/fall pulses on each accepted level change.
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ena,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            // Any sample agreeing with the accepted level restarts the stable-time count.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
                r_rise  <= i_ena & r_sync2;
                r_fall  <= i_ena & ~r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw button bus for timer_counter: one independent
// debounce_channel per bit, nothing else.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int N_BTN           = N_BTN_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    button_conditioner_if.slave bus
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .i_ena  (bus.ena),
            .i_raw  (bus.btn_raw[g]),
            .o_level(bus.btn_level[g]),
            .o_rise (bus.btn_rise[g]),
            .o_fall (bus.btn_fall[g])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a 4-cycle debounce window.
// Edges are counted from the first rising edge after btn_raw changes.
module tb_button_conditioner;

    logic clk;
    logic rst;
    int   n_run;
    int   n_fail;
    int   n_rise1;
    logic [3:0] acc_rise;
    logic [3:0] acc_fall;
    logic [3:0] acc_level;

    button_conditioner_if #(.N_BTN(4)) bus ();

    button_conditioner #(
        .N_BTN          (4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_run       = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.ena     = 1'b1;
        bus.btn_raw = 4'hF;

        // 1. reset with all inputs high, then qualification of all four bits
        tick(3);
        check("rst_level", bus.btn_level, 4'h0);
        check("rst_rise",  bus.btn_rise,  4'h0);
        check("rst_fall",  bus.btn_fall,  4'h0);
        rst = 1'b0;
        tick(5);
        check("t1_level_e5", bus.btn_level, 4'h0);
        tick(1);
        check("t1_level_e6", bus.btn_level, 4'hF);
        check("t1_rise_e6",  bus.btn_rise,  4'hF);
        tick(1);
        check("t1_rise_e7",  bus.btn_rise,  4'h0);
        check("t1_level_e7", bus.btn_level, 4'hF);

        bus.btn_raw = 4'h0;
        tick(6);
        check("t1_fall_e6",   bus.btn_fall,  4'hF);
        check("t1_level_off", bus.btn_level, 4'h0);
        tick(1);
        check("t1_fall_e7",   bus.btn_fall,  4'h0);

        // 2. clean press and release on START
        bus.btn_raw = 4'b0100;
        tick(5);
        check("t2_level_e5", bus.btn_level, 4'h0);
        check("t2_rise_e5",  bus.btn_rise,  4'h0);
        tick(1);
        check("t2_level_e6", bus.btn_level, 4'b0100);
        check("t2_rise_e6",  bus.btn_rise,  4'b0100);
        check("t2_fall_e6",  bus.btn_fall,  4'h0);
        tick(1);
        check("t2_rise_e7",  bus.btn_rise,  4'h0);
        bus.btn_raw = 4'b0000;
        tick(5);
        check("t2_fall_e5",  bus.btn_fall,  4'h0);
        tick(1);
        check("t2_fall_e6",  bus.btn_fall,  4'b0100);
        check("t2_lvl_rel",  bus.btn_level, 4'h0);
        tick(1);
        check("t2_fall_e7",  bus.btn_fall,  4'h0);

        // 3. STOP high for 3 cycles only: one short of qualifying
        acc_rise  = 4'h0;
        acc_fall  = 4'h0;
        acc_level = 4'h0;
        bus.btn_raw = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            acc_rise  = acc_rise  | bus.btn_rise;
            acc_fall  = acc_fall  | bus.btn_fall;
            acc_level = acc_level | bus.btn_level;
        end
        bus.btn_raw = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            acc_rise  = acc_rise  | bus.btn_rise;
            acc_fall  = acc_fall  | bus.btn_fall;
            acc_level = acc_level | bus.btn_level;
        end
        check("t3_glitch_level", acc_level, 4'h0);
        check("t3_glitch_rise",  acc_rise,  4'h0);
        check("t3_glitch_fall",  acc_fall,  4'h0);

        // 4. MODE bounces 1,0,1,0 then holds 1
        n_rise1  = 0;
        acc_rise = 4'h0;
        bus.btn_raw = 4'b0010; tick(1); acc_rise = acc_rise | bus.btn_rise;
        bus.btn_raw = 4'b0000; tick(1); acc_rise = acc_rise | bus.btn_rise;
        bus.btn_raw = 4'b0010; tick(1); acc_rise = acc_rise | bus.btn_rise;
        bus.btn_raw = 4'b0000; tick(1); acc_rise = acc_rise | bus.btn_rise;
        bus.btn_raw = 4'b0010;
        tick(5);
        acc_rise = acc_rise | bus.btn_rise;
        check("t4_no_early_rise", acc_rise, 4'h0);
        check("t4_level_e5",      bus.btn_level, 4'h0);
        tick(1);
        check("t4_rise_e6",  bus.btn_rise,  4'b0010);
        check("t4_level_e6", bus.btn_level, 4'b0010);
        for (int i = 0; i < 6; i++) begin
            if (bus.btn_rise[1]) n_rise1++;
            tick(1);
        end
        check("t4_rise_count", 4'(n_rise1), 4'd1);
        bus.btn_raw = 4'b0000;
        tick(8);
        check("t4_release", bus.btn_level, 4'h0);

        // 5. INV qualifies with ena low: level moves, pulse is lost for good
        bus.ena     = 1'b0;
        bus.btn_raw = 4'b0001;
        tick(6);
        check("t5_level_e6", bus.btn_level, 4'b0001);
        check("t5_rise_e6",  bus.btn_rise,  4'h0);
        bus.ena  = 1'b1;
        acc_rise = 4'h0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            acc_rise = acc_rise | bus.btn_rise;
        end
        check("t5_no_deferred", acc_rise, 4'h0);

        // 6. reset while START is at cnt=2, INV still held high
        bus.btn_raw = 4'b0101;
        tick(4);
        rst = 1'b1;
        #1;
        check("t6_rst_level", bus.btn_level, 4'h0);
        check("t6_rst_rise",  bus.btn_rise,  4'h0);
        tick(1);
        rst = 1'b0;
        tick(5);
        check("t6_level_e5", bus.btn_level, 4'h0);
        tick(1);
        check("t6_level_e6", bus.btn_level, 4'b0101);
        check("t6_rise_e6",  bus.btn_rise,  4'b0101);
        tick(1);
        check("t6_rise_e7",  bus.btn_rise,  4'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
